x_multi_load_ctr: RTL and testbench

Parametrised multi-channel successor to the single 8-bit loadable DUT driven by the X testbench interface. It holds CHANNELS independent WIDTH-bit registers. Each channel can be parallel-loaded, counted up or down, and run in wrap or saturate mode, with a per-channel terminal-count flag and a sticky overflow flag. It sits behind the TB clocking block as the DUT, with every output registered on clk.

---
 rtl/x_multi_load_ctr.sv | 117 +++++++++++
 tb/tb_x_multi_load_ctr.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_multi_load_ctr.sv
// ---------------------------------------------------------------------------
// x_multi_load_ctr
//
// Multi-channel loadable up/down counter. Holds CHANNELS independent
// WIDTH-bit registers. Each channel can be parallel-loaded or counted up or
// down. Each channel either wraps or saturates at its boundaries, and has a
// registered terminal-count flag and a sticky overflow/underflow flag.
//
// Parameters:
//   WIDTH    - bit width of each channel register (>= 2)
//   CHANNELS - number of independent channels (>= 1)
//   SATURATE - 0 = wrap at boundaries, 1 = hold at boundaries
//
// Ports:
//   clk      in   single clock, all state updates on posedge
//   reset_l  in   asynchronous active-low reset
//   din      in   load values, channel i at [i*WIDTH +: WIDTH]
//   load     in   per-channel synchronous parallel load (highest priority)
//   en       in   per-channel count enable
//   up       in   per-channel direction, 1 = increment, 0 = decrement
//   ovf_clr  in   per-channel clear of the sticky overflow flag
//   dout     out  channel register values, same packing as din
//   tc       out  registered terminal count per channel
//   ovf      out  sticky overflow/underflow flag per channel
// ---------------------------------------------------------------------------
module x_multi_load_ctr #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      reset_l,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       up,
    input  logic [CHANNELS-1:0]       ovf_clr,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL  = '1;
    localparam logic             SAT_MODE = (SATURATE != 0);

    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [WIDTH-1:0]    count_d [CHANNELS];
    logic [CHANNELS-1:0] bnd_evt;
    logic [CHANNELS-1:0] ovf_q;
    logic [CHANNELS-1:0] ovf_d;
    logic [CHANNELS-1:0] tc_q;
    logic [CHANNELS-1:0] tc_d;

    // Next-state logic for every channel: load beats count beats hold.
    // A boundary event is raised only by an enabled count that sits at the
    // boundary for its direction. A load never raises one.
    // The sticky flag gives priority to a new event over a clear in the same
    // cycle. The terminal count looks at the value the channel is about to
    // hold and at the current direction. That lets a direction change with
    // the count disabled still update tc on the next edge.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            count_d[i] = count_q[i];
            bnd_evt[i] = 1'b0;

            if (load[i]) begin
                count_d[i] = din[i*WIDTH +: WIDTH];
            end else if (en[i]) begin
                if (up[i]) begin
                    if (count_q[i] == MAX_VAL) begin
                        bnd_evt[i] = 1'b1;
                        count_d[i] = SAT_MODE ? MAX_VAL : '0;
                    end else begin
                        count_d[i] = count_q[i] + 1'b1;
                    end
                end else begin
                    if (count_q[i] == '0) begin
                        bnd_evt[i] = 1'b1;
                        count_d[i] = SAT_MODE ? '0 : MAX_VAL;
                    end else begin
                        count_d[i] = count_q[i] - 1'b1;
                    end
                end
            end

            ovf_d[i] = bnd_evt[i] | (ovf_q[i] & ~ovf_clr[i]);
            tc_d[i]  = up[i] ? (count_d[i] == MAX_VAL) : (count_d[i] == '0);
        end
    end

    // State registers. Reset clears everything at once, tc included. The
    // first real tc value therefore appears on the first edge after release.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= '0;
            end
            ovf_q <= '0;
            tc_q  <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i] <= count_d[i];
            end
            ovf_q <= ovf_d;
            tc_q  <= tc_d;
        end
    end

    // Pack the channel registers onto the flat output bus.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_pack
        assign dout[g*WIDTH +: WIDTH] = count_q[g];
    end

    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_x_multi_load_ctr.sv
// ---------------------------------------------------------------------------
// tb_x_multi_load_ctr
//
// Drives four instances of the counter side by side:
//   A: WIDTH=8,  CHANNELS=4, wrap
//   S: WIDTH=8,  CHANNELS=4, saturate
//   N: WIDTH=4,  CHANNELS=1, wrap
//   W: WIDTH=16, CHANNELS=8, wrap
// A reference model tracks each channel with plain integer arithmetic.
// Directed scenarios and a random sweep compare the outputs against it.
// ---------------------------------------------------------------------------
module tb_x_multi_load_ctr;

    logic clk;
    logic reset_l;

    logic [31:0]  a_din,  s_din;
    logic [3:0]   a_load, a_en, a_up, a_clr, a_tc, a_ovf;
    logic [3:0]   s_load, s_en, s_up, s_clr, s_tc, s_ovf;
    logic [31:0]  a_dout, s_dout;
    logic [3:0]   n_din, n_dout;
    logic [0:0]   n_load, n_en, n_up, n_clr, n_tc, n_ovf;
    logic [127:0] w_din, w_dout;
    logic [7:0]   w_load, w_en, w_up, w_clr, w_tc, w_ovf;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state: instance k (0=A,1=S,2=N,3=W), channel c.
    int mv [4][8];
    bit mo [4][8];
    bit mt [4][8];

    x_multi_load_ctr #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) dutA (
        .clk(clk), .reset_l(reset_l), .din(a_din), .load(a_load), .en(a_en),
        .up(a_up), .ovf_clr(a_clr), .dout(a_dout), .tc(a_tc), .ovf(a_ovf));

    x_multi_load_ctr #(.WIDTH(8), .CHANNELS(4), .SATURATE(1)) dutS (
        .clk(clk), .reset_l(reset_l), .din(s_din), .load(s_load), .en(s_en),
        .up(s_up), .ovf_clr(s_clr), .dout(s_dout), .tc(s_tc), .ovf(s_ovf));

    x_multi_load_ctr #(.WIDTH(4), .CHANNELS(1), .SATURATE(0)) dutN (
        .clk(clk), .reset_l(reset_l), .din(n_din), .load(n_load), .en(n_en),
        .up(n_up), .ovf_clr(n_clr), .dout(n_dout), .tc(n_tc), .ovf(n_ovf));

    x_multi_load_ctr #(.WIDTH(16), .CHANNELS(8), .SATURATE(0)) dutW (
        .clk(clk), .reset_l(reset_l), .din(w_din), .load(w_load), .en(w_en),
        .up(w_up), .ovf_clr(w_clr), .dout(w_dout), .tc(w_tc), .ovf(w_ovf));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int widthOf(int k);
        case (k)
            2: return 4;
            3: return 16;
            default: return 8;
        endcase
    endfunction

    function automatic int chansOf(int k);
        case (k)
            2: return 1;
            3: return 8;
            default: return 4;
        endcase
    endfunction

    // One model step for one channel, written from the counting rules:
    // the value is old +/- 1 taken modulo 2^W when wrapping, or clamped to
    // [0, max] when saturating. An event is any enabled count that would
    // leave that range.
    function automatic void modelStep(int k, int c, bit ld, bit e, bit u,
                                      bit clr, int d);
        int maxv;
        int old;
        int nv;
        bit ev;
        bit sat;
        maxv = (1 << widthOf(k)) - 1;
        sat  = (k == 1);
        old  = mv[k][c];
        ev   = 1'b0;
        if (ld) begin
            nv = d;
        end else if (e && u) begin
            ev = (old + 1 > maxv);
            nv = sat ? ((old + 1 > maxv) ? maxv : old + 1) : (old + 1) % (maxv + 1);
        end else if (e) begin
            ev = (old - 1 < 0);
            nv = sat ? ((old == 0) ? 0 : old - 1) : (old - 1 + maxv + 1) % (maxv + 1);
        end else begin
            nv = old;
        end
        mv[k][c] = nv;
        mo[k][c] = ev | (mo[k][c] & ~clr);
        mt[k][c] = u ? (nv == maxv) : (nv == 0);
    endfunction

    function automatic void resetModel();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 8; c++) begin
                mv[k][c] = 0;
                mo[k][c] = 1'b0;
                mt[k][c] = 1'b0;
            end
        end
    endfunction

    function automatic logic [127:0] expDout(int k);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < chansOf(k); c++) begin
            r = r | (128'(unsigned'(mv[k][c])) << (c * widthOf(k)));
        end
        return r;
    endfunction

    function automatic logic [7:0] expTc(int k);
        logic [7:0] r;
        r = '0;
        for (int c = 0; c < chansOf(k); c++) r[c] = mt[k][c];
        return r;
    endfunction

    function automatic logic [7:0] expOvf(int k);
        logic [7:0] r;
        r = '0;
        for (int c = 0; c < chansOf(k); c++) r[c] = mo[k][c];
        return r;
    endfunction

    function automatic logic [127:0] actDout(int k);
        case (k)
            0: return 128'(a_dout);
            1: return 128'(s_dout);
            2: return 128'(n_dout);
            default: return w_dout;
        endcase
    endfunction

    function automatic logic [7:0] actTc(int k);
        case (k)
            0: return 8'(a_tc);
            1: return 8'(s_tc);
            2: return 8'(n_tc);
            default: return w_tc;
        endcase
    endfunction

    function automatic logic [7:0] actOvf(int k);
        case (k)
            0: return 8'(a_ovf);
            1: return 8'(s_ovf);
            2: return 8'(n_ovf);
            default: return w_ovf;
        endcase
    endfunction

    function automatic int pickDin(int w);
        int maxv;
        maxv = (1 << w) - 1;
        case ($urandom % 3)
            0: return int'($urandom_range(0, 2));
            1: return maxv - int'($urandom_range(0, 2));
            default: return int'($urandom) & maxv;
        endcase
    endfunction

    task automatic clearInputs();
        a_din = '0; a_load = '0; a_en = '0; a_up = '0; a_clr = '0;
        s_din = '0; s_load = '0; s_en = '0; s_up = '0; s_clr = '0;
        n_din = '0; n_load = '0; n_en = '0; n_up = '0; n_clr = '0;
        w_din = '0; w_load = '0; w_en = '0; w_up = '0; w_clr = '0;
    endtask

    // Feeds the inputs currently driven to the model, then advances one
    // clock. Outputs are sampled 1 time unit after the edge.
    task automatic cycle();
        for (int c = 0; c < 4; c++) begin
            modelStep(0, c, a_load[c], a_en[c], a_up[c], a_clr[c], int'(a_din[c*8 +: 8]));
            modelStep(1, c, s_load[c], s_en[c], s_up[c], s_clr[c], int'(s_din[c*8 +: 8]));
        end
        modelStep(2, 0, n_load[0], n_en[0], n_up[0], n_clr[0], int'(n_din));
        for (int c = 0; c < 8; c++) begin
            modelStep(3, c, w_load[c], w_en[c], w_up[c], w_clr[c], int'(w_din[c*16 +: 16]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_l = 1'b0;
        clearInputs();
        resetModel();
        repeat (2) @(posedge clk);
        #1;
        nChecks++;
        if (a_dout !== 32'h0 || a_ovf !== 4'h0 || a_tc !== 4'h0) begin
            nFails++;
            $display("[TB] FAIL reset_A got dout=%h ovf=%b tc=%b exp 0/0/0", a_dout, a_ovf, a_tc);
        end
        nChecks++;
        if (w_dout !== 128'h0 || w_ovf !== 8'h0 || w_tc !== 8'h0) begin
            nFails++;
            $display("[TB] FAIL reset_W got dout=%h ovf=%b tc=%b exp 0/0/0", w_dout, w_ovf, w_tc);
        end

        // The first edge after release with up=0 everywhere reports tc=1.
        reset_l = 1'b1;
        cycle();
        nChecks++;
        if (a_tc !== 4'hF) begin
            nFails++;
            $display("[TB] FAIL reset_tc_first got=%b exp=1111", a_tc);
        end

        // Count ch0 to 37, then drop reset between edges.
        a_load[0] = 1'b1; a_din[7:0] = 8'd36;
        cycle();
        a_load[0] = 1'b0; a_en[0] = 1'b1; a_up[0] = 1'b1;
        cycle();
        nChecks++;
        if (a_dout[7:0] !== 8'd37) begin
            nFails++;
            $display("[TB] FAIL reset_precount got=%0d exp=37", a_dout[7:0]);
        end
        #2;
        reset_l = 1'b0;
        #1;
        nChecks++;
        if (a_dout !== 32'h0 || a_ovf !== 4'h0 || a_tc !== 4'h0) begin
            nFails++;
            $display("[TB] FAIL reset_async got dout=%h ovf=%b tc=%b exp 0/0/0", a_dout, a_ovf, a_tc);
        end
        resetModel();
        #1;
        reset_l = 1'b1;
        cycle();
        nChecks++;
        if (a_dout[7:0] !== 8'd1) begin
            nFails++;
            $display("[TB] FAIL reset_first_count got=%0d exp=1", a_dout[7:0]);
        end
        clearInputs();
        cycle();
    endtask

    task automatic test_load_priority();
        logic [7:0] expv [3];
        expv = '{8'd200, 8'd201, 8'd202};
        a_load[1] = 1'b1; a_en[1] = 1'b1; a_up[1] = 1'b1; a_din[15:8] = 8'd200;
        for (int i = 0; i < 3; i++) begin
            cycle();
            a_load[1] = 1'b0;
            nChecks++;
            if (a_dout[15:8] !== expv[i]) begin
                nFails++;
                $display("[TB] FAIL load_prio step%0d got=%0d exp=%0d", i, a_dout[15:8], expv[i]);
            end
            nChecks++;
            if (128'(a_dout) !== expDout(0)) begin
                nFails++;
                $display("[TB] FAIL load_hold step%0d got=%h exp=%h", i, a_dout, expDout(0));
            end
        end
        clearInputs();
    endtask

    task automatic test_wrap();
        logic [7:0] expv [6];
        logic       expTcv [6];
        logic       expOv [6];
        expv   = '{8'd254, 8'd255, 8'd0, 8'd1, 8'd0, 8'd255};
        expTcv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        expOv  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        a_load[2] = 1'b1; a_din[23:16] = 8'd254; a_up[2] = 1'b1; a_clr[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            a_load[2] = 1'b0; a_clr[2] = 1'b0; a_en[2] = 1'b1;
            a_up[2] = (i < 3);
            nChecks++;
            if (a_dout[23:16] !== expv[i] || a_tc[2] !== expTcv[i] || a_ovf[2] !== expOv[i]) begin
                nFails++;
                $display("[TB] FAIL wrap step%0d got val=%0d tc=%b ovf=%b exp val=%0d tc=%b ovf=%b",
                         i, a_dout[23:16], a_tc[2], a_ovf[2], expv[i], expTcv[i], expOv[i]);
            end
        end
        clearInputs();
    endtask

    task automatic test_saturate();
        logic expOv [5];
        expOv = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        s_load[0] = 1'b1; s_din[7:0] = 8'd254; s_up[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            s_load[0] = 1'b0; s_en[0] = 1'b1;
            nChecks++;
            if (s_dout[7:0] !== ((i == 0) ? 8'd254 : 8'd255) || s_ovf[0] !== expOv[i]) begin
                nFails++;
                $display("[TB] FAIL sat_up step%0d got val=%0d ovf=%b exp val=%0d ovf=%b",
                         i, s_dout[7:0], s_ovf[0], (i == 0) ? 254 : 255, expOv[i]);
            end
        end
        s_load[0] = 1'b1; s_din[7:0] = 8'd0; s_en[0] = 1'b0; s_up[0] = 1'b0; s_clr[0] = 1'b1;
        cycle();
        nChecks++;
        if (s_dout[7:0] !== 8'd0 || s_ovf[0] !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL sat_load0 got val=%0d ovf=%b exp val=0 ovf=0", s_dout[7:0], s_ovf[0]);
        end
        s_load[0] = 1'b0; s_clr[0] = 1'b0; s_en[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            nChecks++;
            if (s_dout[7:0] !== 8'd0 || s_ovf[0] !== 1'b1 || s_tc[0] !== 1'b1) begin
                nFails++;
                $display("[TB] FAIL sat_down step%0d got val=%0d ovf=%b tc=%b exp val=0 ovf=1 tc=1",
                         i, s_dout[7:0], s_ovf[0], s_tc[0]);
            end
        end
        clearInputs();
    endtask

    task automatic test_sticky();
        a_load[3] = 1'b1; a_din[31:24] = 8'd255; a_up[3] = 1'b1;
        cycle();
        a_load[3] = 1'b0; a_en[3] = 1'b1;
        cycle();
        nChecks++;
        if (a_ovf[3] !== 1'b1 || a_dout[31:24] !== 8'd0) begin
            nFails++;
            $display("[TB] FAIL sticky_set got ovf=%b val=%0d exp ovf=1 val=0", a_ovf[3], a_dout[31:24]);
        end
        a_en[3] = 1'b0; a_clr[3] = 1'b1;
        cycle();
        nChecks++;
        if (a_ovf[3] !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL sticky_clr got=%b exp=0", a_ovf[3]);
        end
        a_clr[3] = 1'b0; a_load[3] = 1'b1;
        cycle();
        a_load[3] = 1'b0; a_en[3] = 1'b1; a_clr[3] = 1'b1;
        cycle();
        nChecks++;
        if (a_ovf[3] !== 1'b1 || a_dout[31:24] !== 8'd0) begin
            nFails++;
            $display("[TB] FAIL sticky_set_wins got ovf=%b val=%0d exp ovf=1 val=0", a_ovf[3], a_dout[31:24]);
        end
        clearInputs();
    endtask

    task automatic test_ch7_wrap();
        w_load[7] = 1'b1; w_din[127:112] = 16'd65534; w_up[7] = 1'b1;
        w_load[6] = 1'b1; w_din[111:96]  = 16'd1000;  w_up[6] = 1'b1; w_clr[6] = 1'b1;
        cycle();
        w_load = '0; w_clr = '0; w_en[7] = 1'b1;
        cycle();
        cycle();
        nChecks++;
        if (w_dout[127:112] !== 16'd0 || w_ovf[7] !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL ch7_wrap got val=%0d ovf=%b exp val=0 ovf=1", w_dout[127:112], w_ovf[7]);
        end
        nChecks++;
        if (w_dout[111:96] !== 16'd1000 || w_ovf[6] !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ch6_undisturbed got val=%0d ovf=%b exp val=1000 ovf=0", w_dout[111:96], w_ovf[6]);
        end
        clearInputs();
    endtask

    task automatic test_random(int nCycles);
        for (int n = 0; n < nCycles; n++) begin
            for (int c = 0; c < 4; c++) begin
                a_load[c] = ($urandom % 8 == 0); a_en[c] = ($urandom % 4 != 0);
                a_up[c] = $urandom % 2; a_clr[c] = ($urandom % 16 == 0);
                a_din[c*8 +: 8] = 8'(pickDin(8));
                s_load[c] = ($urandom % 8 == 0); s_en[c] = ($urandom % 4 != 0);
                s_up[c] = $urandom % 2; s_clr[c] = ($urandom % 16 == 0);
                s_din[c*8 +: 8] = 8'(pickDin(8));
            end
            n_load[0] = ($urandom % 8 == 0); n_en[0] = ($urandom % 4 != 0);
            n_up[0] = $urandom % 2; n_clr[0] = ($urandom % 16 == 0);
            n_din = 4'(pickDin(4));
            for (int c = 0; c < 8; c++) begin
                w_load[c] = ($urandom % 6 == 0); w_en[c] = ($urandom % 4 != 0);
                w_up[c] = $urandom % 2; w_clr[c] = ($urandom % 16 == 0);
                w_din[c*16 +: 16] = 16'(pickDin(16));
            end
            cycle();
            for (int k = 0; k < 4; k++) begin
                nChecks++;
                if (actDout(k) !== expDout(k)) begin
                    nFails++;
                    $display("[TB] FAIL rand_dout inst=%0d cyc=%0d got=%h exp=%h", k, n, actDout(k), expDout(k));
                end
                nChecks++;
                if (actTc(k) !== expTc(k)) begin
                    nFails++;
                    $display("[TB] FAIL rand_tc inst=%0d cyc=%0d got=%b exp=%b", k, n, actTc(k), expTc(k));
                end
                nChecks++;
                if (actOvf(k) !== expOvf(k)) begin
                    nFails++;
                    $display("[TB] FAIL rand_ovf inst=%0d cyc=%0d got=%b exp=%b", k, n, actOvf(k), expOvf(k));
                end
            end
        end
        clearInputs();
    endtask

    initial begin
        test_reset();
        test_load_priority();
        test_wrap();
        test_saturate();
        test_sticky();
        test_ch7_wrap();
        test_random(400);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
